// File: rtl/cmdq_pkg.sv
// ============================================================================
// cmdq_pkg : command-word field layout and queue defaults for cmdq_fifo
// Rev 1.0
// ============================================================================
`default_nettype none

package cmdq_pkg;

    localparam int ROW_W  = 14;
    localparam int BANK_W = 3;
    localparam int COL_W  = 9;
    localparam int RANK_W = 2;
    localparam int RW_W   = 1;
    localparam int CMD_W  = ROW_W + BANK_W + COL_W + RANK_W + RW_W;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BANK_W-1:0] bank;
        logic [COL_W-1:0]  col;
        logic [RANK_W-1:0] rank;
        logic [RW_W-1:0]   rw;
    } cmd_t;

    localparam int DEPTH_DEF      = 16;
    localparam int AFULL_OFF_DEF  = 4;
    localparam int AEMPTY_OFF_DEF = 2;

    // Output-stage states
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_VALID = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cmdq_ram.sv
// ============================================================================
// cmdq_ram : DEPTH x W simple dual-port storage, synchronous write,
//            asynchronous read feeding the queue's registered output stage.
// Rev 1.0
// ============================================================================
`default_nettype none

module cmdq_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 29,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/cmdq_fifo.sv
// ============================================================================
// cmdq_fifo : parametrised FWFT command queue with thresholds, occupancy and
//             sticky overflow/underflow. Optional parity: CMDQ_PARITY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module cmdq_fifo
    import cmdq_pkg::*;
#(
    parameter int DW            = CMD_W,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int AFULL_OFFSET  = AFULL_OFF_DEF,
    parameter int AEMPTY_OFFSET = AEMPTY_OFF_DEF
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [DW-1:0]                WD,
    input  logic                         WEn,
    output logic                         Full,
    output logic                         HardFull,
    output logic [DW-1:0]                RD,
    output logic                         Empty,
    output logic                         AEmpty,
    input  logic                         REn,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Overflow,
    output logic                         Underflow,
    input  logic                         InjErr,
    output logic                         ParErr
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
`ifdef CMDQ_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_AFULL  = CW'(DEPTH - AFULL_OFFSET);
    localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_OFFSET);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] rd_q, rd_d;
    logic [0:0]    st_q, st_d;
    logic          full_q, hfull_q, aempty_q;
    logic          ovf_q, unf_q, perr_q, perr_d;
    logic          empty_w, wr_acc, rd_acc;
    logic [MW-1:0] wdata_w, ram_rdata, head_w;

    assign wr_acc = WEn && (!hfull_q || REn);
    assign rd_acc = REn && !empty_w;

`ifdef CMDQ_PARITY_EN
    assign wdata_w = {(^WD) ^ InjErr, WD};
`else
    assign wdata_w = WD;
`endif

    cmdq_ram #(
        .DEPTH (DEPTH),
        .W     (MW)
    ) u_ram (
        .clk_i   (Clock),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (wdata_w),
        .raddr_i (rptr_d),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wptr_d  = wr_acc ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = rd_acc ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // The word being written becomes the head when nothing older remains
        head_w = (wr_acc && (rptr_d == wptr_q)) ? wdata_w : ram_rdata;
        rd_d   = (count_d != '0) ? head_w[DW-1:0] : rd_q;
`ifdef CMDQ_PARITY_EN
        perr_d = (count_d != '0) && ((^head_w[DW-1:0]) != head_w[DW]);
`else
        perr_d = 1'b0;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rd_q     <= '0;
            full_q   <= 1'b0;
            hfull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
            full_q   <= (count_d >= C_AFULL);
            hfull_q  <= (count_d == C_DEPTH);
            aempty_q <= (count_d <= C_AEMPTY);
            ovf_q    <= ovf_q | (WEn && !wr_acc);
            unf_q    <= unf_q | (REn && empty_w);
            perr_q   <= perr_d;
        end
    end

    // Output stage: state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            st_q <= ST_EMPTY;
        end else begin
            st_q <= st_d;
        end
    end

    // Output stage: next state
    always_comb begin
        st_d = st_q;
        case (st_q)
            ST_EMPTY: if (wr_acc) st_d = ST_VALID;
            ST_VALID: if (rd_acc && !wr_acc && (count_q == CW'(1))) st_d = ST_EMPTY;
            default:  st_d = ST_EMPTY;
        endcase
    end

    // Output stage: outputs
    always_comb begin
        empty_w = (st_q == ST_EMPTY);
    end

    assign Empty     = empty_w;
    assign RD        = rd_q;
    assign Count     = count_q;
    assign Full      = full_q;
    assign HardFull  = hfull_q;
    assign AEmpty    = aempty_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign ParErr    = perr_q;

`ifndef CMDQ_PARITY_EN
    logic unused_injerr;
    assign unused_injerr = InjErr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cmdq_fifo.sv
// ============================================================================
// tb_cmdq_fifo : directed + randomized bench for cmdq_fifo against a
//                queue-based reference model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cmdq_fifo;
    import cmdq_pkg::*;

    localparam int DW     = CMD_W;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 4;
    localparam int AEMPTY = 2;
    localparam int CW     = $clog2(DEPTH+1);

    logic          Clock, Reset, WEn, REn, InjErr;
    logic [DW-1:0] WD, RD;
    logic          Full, HardFull, Empty, AEmpty, Overflow, Underflow, ParErr;
    logic [CW-1:0] Count;

    int n_chk  = 0;
    int n_fail = 0;

    cmdq_fifo #(
        .DW            (DW),
        .DEPTH         (DEPTH),
        .AFULL_OFFSET  (AFULL),
        .AEMPTY_OFFSET (AEMPTY)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .WD        (WD),
        .WEn       (WEn),
        .Full      (Full),
        .HardFull  (HardFull),
        .RD        (RD),
        .Empty     (Empty),
        .AEmpty    (AEmpty),
        .REn       (REn),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .InjErr    (InjErr),
        .ParErr    (ParErr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words
    typedef struct packed {
        logic          inj;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] m_rd;
    logic          m_ovf, m_unf;
    bit            m_valid = 1'b0;

    always @(posedge Clock) begin : model
        bit do_rd, do_wr;
        ent_t e;
        if (Reset) begin
            mq.delete();
            m_rd    = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            do_rd = REn && (mq.size() != 0);
            do_wr = WEn && ((mq.size() < DEPTH) || REn);
            if (WEn && !do_wr) m_ovf = 1'b1;
            if (REn && mq.size() == 0) m_unf = 1'b1;
            if (do_rd) void'(mq.pop_front());
            if (do_wr) begin
                e.d   = WD;
                e.inj = InjErr;
                mq.push_back(e);
            end
            if (mq.size() != 0) m_rd = mq[0].d;
        end
    end

    always @(negedge Clock) begin : compare
        int  n;
        logic exp_pe;
        if (m_valid) begin
            n = mq.size();
`ifdef CMDQ_PARITY_EN
            exp_pe = (n > 0) && mq[0].inj;
`else
            exp_pe = 1'b0;
`endif
            chk("m_Count",     Count,     n);
            chk("m_Empty",     Empty,     n == 0);
            chk("m_Full",      Full,      n >= DEPTH - AFULL);
            chk("m_HardFull",  HardFull,  n == DEPTH);
            chk("m_AEmpty",    AEmpty,    n <= AEMPTY);
            chk("m_Overflow",  Overflow,  m_ovf);
            chk("m_Underflow", Underflow, m_unf);
            chk("m_RD",        RD,        m_rd);
            chk("m_ParErr",    ParErr,    exp_pe);
        end
    end

    task automatic cyc(input logic we, input logic re, input logic [DW-1:0] d, input logic inj);
        WEn = we; REn = re; WD = d; InjErr = inj;
        @(posedge Clock); #1;
        WEn = 1'b0; REn = 1'b0; InjErr = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
    endtask

    initial begin : stim
        int wp, rp;
        WEn = 1'b0; REn = 1'b0; WD = '0; InjErr = 1'b0; Reset = 1'b1;
        @(posedge Clock); @(posedge Clock); #1;
        Reset = 1'b0;

        chk("rst_Empty",  Empty,  1);
        chk("rst_Count",  Count,  0);
        chk("rst_AEmpty", AEmpty, 1);
        chk("rst_Full",   Full,   0);
        chk("rst_RD",     RD,     0);

        cyc(1'b1, 1'b0, DW'(32'h0ABCDEF0), 1'b0);
        chk("w1_Empty",  Empty,  0);
        chk("w1_RD",     RD,     64'h0ABCDEF0);
        chk("w1_Count",  Count,  1);
        chk("w1_AEmpty", AEmpty, 1);
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("r1_Empty", Empty, 1);
        chk("r1_Count", Count, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, DW'(i), 1'b0);
            chk("fill_Full",  Full,     (i + 1) >= 12);
            chk("fill_HFull", HardFull, i == 15);
        end
        cyc(1'b1, 1'b0, DW'(99), 1'b0);
        chk("ovf_Overflow", Overflow, 1);
        chk("ovf_Count",    Count,    16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_RD",    RD,    i);
            chk("drain_Empty", Empty, 0);
            cyc(1'b0, 1'b1, '0, 1'b0);
        end
        chk("drain_done", Empty, 1);

        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, DW'(i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            chk("wrap_RD", RD, k);
            cyc(1'b1, 1'b1, DW'(16 + k), 1'b0);
            chk("wrap_Count", Count,    16);
            chk("wrap_Ovf",   Overflow, 0);
        end
        for (int i = 0; i < 16; i++) begin
            chk("wrap_drain_RD", RD, 20 + i);
            cyc(1'b0, 1'b1, '0, 1'b0);
        end

        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("unf_Underflow", Underflow, 1);
        chk("unf_Count",     Count,     0);
        chk("unf_RD",        RD,        35);

        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, DW'(100 + i), 1'b0);
        chk("pre_rst_Count", Count, 7);
        WEn = 1'b1; REn = 1'b1; Reset = 1'b1;
        @(posedge Clock); #1;
        WEn = 1'b0; REn = 1'b0; Reset = 1'b0;
        chk("mid_rst_Count", Count,     0);
        chk("mid_rst_Empty", Empty,     1);
        chk("mid_rst_Ovf",   Overflow,  0);
        chk("mid_rst_Unf",   Underflow, 0);

        cyc(1'b1, 1'b0, DW'(1), 1'b1);
        cyc(1'b1, 1'b0, DW'(2), 1'b0);
`ifdef CMDQ_PARITY_EN
        chk("par_head_err", ParErr, 1);
`else
        chk("par_head_err", ParErr, 0);
`endif
        cyc(1'b0, 1'b1, '0, 1'b0);
        chk("par_next_ok", ParErr, 0);
        chk("par_next_RD", RD,     2);
        cyc(1'b0, 1'b1, '0, 1'b0);

        for (int c = 0; c < 4000; c++) begin
            case ((c / 500) % 4)
                0:       begin wp = 70; rp = 30; end
                1:       begin wp = 30; rp = 70; end
                2:       begin wp = 90; rp = 90; end
                default: begin wp = 50; rp = 50; end
            endcase
            Reset  = ($urandom_range(0, 299) == 0);
            WEn    = ($urandom_range(0, 99) < wp);
            REn    = ($urandom_range(0, 99) < rp);
            WD     = DW'($urandom);
            InjErr = $urandom_range(0, 1) == 1;
            @(posedge Clock); #1;
        end
        Reset = 1'b0; WEn = 1'b0; REn = 1'b0; InjErr = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
